// File: rtl/eth_sw_pkg.sv
// Shared types for the Ethernet switch egress path.
// Word, buffer-entry and write-FSM state definitions.
package eth_sw_pkg;

    typedef logic [63:0] eth_word_t;

    // Sop is not stored; the read side regenerates it from the previous eop.
    typedef struct packed {
        logic      eop;
        eth_word_t data;
    } buf_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        IN_PKT,
        DISCARD
    } wr_state_e;

endpackage

// File: rtl/eth_sdp_ram.sv
// Simple dual-port flop array: one synchronous write port, async read.
// Ports: clk, wrEn/wrAddr/wrData (write), rdAddr/rdData (read).
module eth_sdp_ram #(
    parameter int  DEPTH = 64,
    parameter type T     = logic [64:0],
    parameter int  AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wrEn,
    input  logic [AW-1:0] wrAddr,
    input  T              wrData,
    input  logic [AW-1:0] rdAddr,
    output T              rdData
);

    T mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn) mem[wrAddr] <= wrData;
    end

    assign rdData = mem[rdAddr];

endmodule

// File: rtl/eth_egress_pkt_fifo.sv
// Store-and-forward egress packet FIFO with drop of malformed/oversize packets.
// Ports: clk/resetN; in* stream from switch core; out* ready/valid to MAC;
// pktCnt/dropCnt saturating statistics; level = committed words unread.
module eth_egress_pkt_fifo
    import eth_sw_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic [63:0]            inData,
    input  logic                   inSop,
    input  logic                   inEop,
    input  logic                   inVld,
    output logic [63:0]            outData,
    output logic                   outSop,
    output logic                   outEop,
    output logic                   outVld,
    input  logic                   outRdy,
    output logic [CNT_W-1:0]       pktCnt,
    output logic [CNT_W-1:0]       dropCnt,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] ptr_t;
    localparam ptr_t FULL_CNT = ptr_t'(DEPTH);

    wr_state_e st, stNext;
    ptr_t wrPtr, wrCommit, rdPtr;
    ptr_t wrPtrNext, commitNext, base, loadPtr;
    logic abort, writeWord, fullEff, wrEn;
    logic [1:0] dropInc;
    logic [CNT_W:0] dropSum;
    logic pop, load, firstWord;
    buf_entry_t wrEntry, rdEntry;

    // A Sop inside a packet abandons the partial one; the new word is
    // then written from the last commit point, so fullness uses that base.
    assign abort     = (st == IN_PKT) && inSop;
    assign writeWord = inSop || (st == IN_PKT);
    assign base      = abort ? wrCommit : wrPtr;
    assign fullEff   = (base - rdPtr) == FULL_CNT;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) st <= IDLE;
        else         st <= stNext;
    end

    always_comb begin
        stNext = st;
        if (inVld) begin
            if (!writeWord || fullEff)
                stNext = inEop ? IDLE : DISCARD;
            else
                stNext = inEop ? IDLE : IN_PKT;
        end
    end

    always_comb begin
        wrEn       = 1'b0;
        wrPtrNext  = wrPtr;
        commitNext = wrCommit;
        dropInc    = 2'd0;
        if (inVld) begin
            if (abort) dropInc = dropInc + 2'd1;
            if (writeWord) begin
                if (fullEff) begin
                    wrPtrNext = wrCommit;
                    dropInc   = dropInc + 2'd1;
                end else begin
                    wrEn      = 1'b1;
                    wrPtrNext = base + ptr_t'(1);
                    if (inEop) commitNext = base + ptr_t'(1);
                end
            end else if (st == IDLE) begin
                dropInc = 2'd1;
            end
        end
    end

    assign wrEntry = '{eop: inEop, data: inData};

    eth_sdp_ram #(
        .DEPTH (DEPTH),
        .T     (buf_entry_t)
    ) uRam (
        .clk    (clk),
        .wrEn   (wrEn),
        .wrAddr (base[AW-1:0]),
        .wrData (wrEntry),
        .rdAddr (loadPtr[AW-1:0]),
        .rdData (rdEntry)
    );

    // rdPtr advances only on pop, so the word held in the output register
    // still occupies its slot; the next word to fetch sits one beyond it.
    assign pop     = outVld && outRdy;
    assign loadPtr = rdPtr + ptr_t'(outVld);
    assign load    = (loadPtr != wrCommit) && (!outVld || outRdy);
    assign level   = wrCommit - rdPtr;
    assign dropSum = {1'b0, dropCnt} + (CNT_W + 1)'(dropInc);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wrPtr     <= '0;
            wrCommit  <= '0;
            rdPtr     <= '0;
            outData   <= '0;
            outSop    <= 1'b0;
            outEop    <= 1'b0;
            outVld    <= 1'b0;
            firstWord <= 1'b1;
            pktCnt    <= '0;
            dropCnt   <= '0;
        end else begin
            wrPtr    <= wrPtrNext;
            wrCommit <= commitNext;
            if (pop) rdPtr <= rdPtr + ptr_t'(1);
            if (load) begin
                outData   <= rdEntry.data;
                outSop    <= firstWord;
                outEop    <= rdEntry.eop;
                outVld    <= 1'b1;
                firstWord <= rdEntry.eop;
            end else if (pop) begin
                outVld <= 1'b0;
            end
            if (pop && outEop && (pktCnt != '1))
                pktCnt <= pktCnt + 1'b1;
            dropCnt <= dropSum[CNT_W] ? '1 : dropSum[CNT_W-1:0];
        end
    end

endmodule
